// File: rtl/xor_64bit_reg.sv
// Registered bitwise XOR for the Y86 xorq path. The result and its condition codes
// appear one cycle after an accepted operand pair.
module xor_64bit_reg #(
  parameter int unsigned WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] c,
  output logic             zf,
  output logic             sf,
  output logic             of
);

  logic [WIDTH-1:0] x;

  logic             out_valid_q;
  logic [WIDTH-1:0] c_q;
  logic             zf_q;
  logic             sf_q;
  logic             of_q;

  // One 2-input XOR per bit; no carries, so operand signedness is irrelevant.
  for (genvar i = 0; i < WIDTH; i++) begin : g_xor
    assign x[i] = a[i] ^ b[i];
  end

  // Result and flags only load on an accepted pair so the last result stays readable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      c_q         <= '0;
      zf_q        <= 1'b0;
      sf_q        <= 1'b0;
      of_q        <= 1'b0;
    end else begin
      out_valid_q <= in_valid;
      if (in_valid) begin
        c_q  <= x;
        zf_q <= (x == '0);
        sf_q <= x[WIDTH-1];
        of_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign c         = c_q;
  assign zf        = zf_q;
  assign sf        = sf_q;
  assign of        = of_q;

endmodule

// File: tb/tb_xor_64bit_reg.sv
// Self-checking bench for xor_64bit_reg: directed Y86 xorq cases plus randomized
// streams checked against an arithmetic reference model.
module tb_xor_64bit_reg;

  localparam int unsigned WIDTH = 64;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic [WIDTH-1:0] c;
  logic             zf;
  logic             sf;
  logic             of;

  int checks;
  int errors;

  xor_64bit_reg #(
    .WIDTH(WIDTH)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .c        (c),
    .zf       (zf),
    .sf       (sf),
    .of       (of)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed outputs packed as {out_valid, c, zf, sf, of}.
  function automatic logic [WIDTH+3:0] observed();
    return {out_valid, c, zf, sf, of};
  endfunction

  // Reference: the architectural xorq result and its condition codes.
  function automatic logic [WIDTH+3:0] model(input logic vld, input logic [WIDTH-1:0] res);
    logic zero;
    logic neg;
    zero = (res == 64'd0);
    neg  = ($signed(res) < 0);
    return {vld, res, zero, neg, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [WIDTH-1:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    logic [WIDTH+3:0] exp;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0;
    tick(); tick();
    exp = '0;
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL reset_initial got=%h want=%h", observed(), exp);
    end
    rst_n = 1'b1;
    in_valid = 1'b1; a = 64'd5; b = 64'd3;
    tick();
    exp = {1'b1, 64'd6, 1'b0, 1'b0, 1'b0};
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL reset_first_result got=%h want=%h", observed(), exp);
    end
    // Assert reset mid-cycle while a transfer is pending.
    #3 rst_n = 1'b0;
    #1;
    exp = '0;
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL reset_async got=%h want=%h", observed(), exp);
    end
    tick();
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL reset_held got=%h want=%h", observed(), exp);
    end
    rst_n = 1'b1;
    tick();
    exp = {1'b1, 64'd6, 1'b0, 1'b0, 1'b0};
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL reset_release_first got=%h want=%h", observed(), exp);
    end
  endtask

  task automatic test_zero_ones();
    logic [WIDTH+3:0] exp;
    in_valid = 1'b1; a = '0; b = '0;
    tick();
    exp = {1'b1, 64'd0, 1'b1, 1'b0, 1'b0};
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL zero_xor_zero got=%h want=%h", observed(), exp);
    end
    a = '1; b = '1;
    tick();
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL ones_xor_ones got=%h want=%h", observed(), exp);
    end
  endtask

  task automatic test_directed();
    logic [WIDTH+3:0] exp;
    in_valid = 1'b1;
    a = 64'd1134; b = 64'd8238;
    tick();
    exp = {1'b1, 64'h2440, 1'b0, 1'b0, 1'b0};
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL positive got=%h want=%h", observed(), exp);
    end
    a = -64'sd7478; b = -64'sd46474;
    tick();
    exp = {1'b1, 64'hA8BC, 1'b0, 1'b0, 1'b0};
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL two_negatives got=%h want=%h", observed(), exp);
    end
    a = 64'd1092835; b = -64'sd1020;
    tick();
    exp = {1'b1, 64'hFFFF_FFFF_FFEF_50E7, 1'b0, 1'b1, 1'b0};
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL mixed_sign got=%h want=%h", observed(), exp);
    end
  endtask

  // All directed operands back-to-back, then a random burst, with in_valid held high.
  task automatic test_back_to_back();
    logic [WIDTH-1:0] va[$];
    logic [WIDTH-1:0] vb[$];
    logic [WIDTH+3:0] expq[$];
    logic [WIDTH+3:0] exp;
    va = '{64'd5, 64'd0, '1, 64'd1134, -64'sd7478, 64'd1092835, 64'd7890678653};
    vb = '{64'd3, 64'd0, '1, 64'd8238, -64'sd46474, -64'sd1020, 64'd4238598110567};
    for (int i = 0; i < 20; i++) begin
      va.push_back(rand64());
      vb.push_back(rand64());
    end
    for (int i = 0; i <= va.size(); i++) begin
      if (i < va.size()) begin
        in_valid = 1'b1; a = va[i]; b = vb[i];
        expq.push_back(model(1'b1, va[i] ^ vb[i]));
      end else begin
        in_valid = 1'b0; a = rand64(); b = rand64();
      end
      tick();
      if (i < va.size()) begin
        exp = expq.pop_front();
        checks++;
        if (observed() !== exp) begin
          errors++;
          $display("FAIL stream[%0d] got=%h want=%h", i, observed(), exp);
        end
      end
    end
  endtask

  task automatic test_hold();
    logic [WIDTH+3:0] exp;
    in_valid = 1'b1; a = 64'd7890678653; b = 64'd4238598110567;
    tick();
    exp = model(1'b1, 64'd7890678653 ^ 64'd4238598110567);
    checks++;
    if (observed() !== exp) begin
      errors++;
      $display("FAIL large_values got=%h want=%h", observed(), exp);
    end
    exp[WIDTH+3] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b0; a = rand64(); b = rand64();
      #2;
      a = rand64(); b = rand64();
      tick();
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("FAIL hold[%0d] got=%h want=%h", i, observed(), exp);
      end
    end
  endtask

  // Random valid gaps and identity operands; model keeps only the last accepted result.
  task automatic test_random();
    logic [WIDTH-1:0] last;
    logic [WIDTH-1:0] res;
    logic [WIDTH+3:0] exp;
    logic             vld;
    int unsigned      mode;
    last = 64'd7890678653 ^ 64'd4238598110567;
    for (int i = 0; i < 300; i++) begin
      vld  = 1'($urandom_range(0, 1));
      mode = $urandom_range(0, 3);
      a    = rand64();
      unique case (mode)
        0: begin b = a;           res = '0;     end
        1: begin b = '0;          res = a;      end
        2: begin b = '1;          res = ~a;     end
        default: begin b = rand64(); res = a ^ b; end
      endcase
      in_valid = vld;
      if (vld) last = res;
      tick();
      exp = model(vld, last);
      checks++;
      if (observed() !== exp) begin
        errors++;
        $display("FAIL random[%0d] mode=%0d got=%h want=%h", i, mode, observed(), exp);
      end
    end
    in_valid = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_zero_ones();
    test_directed();
    test_back_to_back();
    test_hold();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
